regfile_writeback_queue: RTL

- Buffers writeback requests from the ALU and load unit and drains them, one per cycle, into the single write port (write_en3/addr3/write_data3) of the 32x32 register file.
- Sits between the execute/memory stages and the register file.
- Publishes a per-register pending-write mask so issue logic can stall on RAW hazards.
- Lets a stall input hold off draining, e.g. while a debug port owns the write port.

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_fifo.sv | 84 ++++++++
 rtl/regfile_writeback_queue.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file writeback queue.
package wb_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  // One-hot register mask used to build the pending-write mask.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
    return NUM_REGS'(1) << r;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular FIFO of writeback entries; exposes storage and valid bits so the
// owner can build hazard masks and forwarding without popping.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  wb_entry_t        entry_i,
  input  logic             pop_i,
  output wb_entry_t        head_c,
  output logic [CNT_W-1:0] count_o,
  output logic             full_c,
  output logic             empty_c,
  output wb_entry_t        entries_o [DEPTH],
  output logic [DEPTH-1:0] valid_o,
  output logic [PTR_W-1:0] rd_ptr_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  wb_entry_t        mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);
  assign do_push = push_i && !full_c;
  assign do_pop  = pop_i && !empty_c;
  assign head_c  = mem_q[rd_ptr_q];

  assign count_o   = count_q;
  assign valid_o   = valid_q;
  assign rd_ptr_o  = rd_ptr_q;
  assign entries_o = mem_q;

  // Pointer, occupancy and valid-bit bookkeeping; pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (do_push) begin
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      valid_d[wr_ptr_q] = 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
      valid_d[rd_ptr_q] = 1'b0;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= entry_i;
      end
    end
  end

endmodule

// File: rtl/regfile_writeback_queue.sv
// Merges ALU and load writebacks into the single register-file write port,
// with a pending-write mask and optional forwarding lookup (macro WB_FWD_EN).
module regfile_writeback_queue
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [REG_ADDR_W-1:0]        ld_rd,
  input  logic [XLEN-1:0]              ld_data,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [REG_ADDR_W-1:0]        alu_rd,
  input  logic [XLEN-1:0]              alu_data,
  input  logic                         stall,
  output logic                         write_en3,
  output logic [REG_ADDR_W-1:0]        addr3,
  output logic [XLEN-1:0]              write_data3,
  output logic [NUM_REGS-1:0]          busy_mask,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  input  logic [REG_ADDR_W-1:0]        fwd_addr,
  output logic                         fwd_hit,
  output logic [XLEN-1:0]              fwd_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        push_entry;
  logic             push;
  logic             pop;
  wb_entry_t        fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  wb_entry_t        fifo_entries [DEPTH];
  logic [DEPTH-1:0] fifo_valid;
  logic [PTR_W-1:0] fifo_rd_ptr;

  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]       data_q, data_d;

  assign ld_ready  = !fifo_full;
  assign alu_ready = !fifo_full && !ld_valid;

  // Load unit wins arbitration; rd==0 writes are accepted but discarded.
  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    if (ld_valid && ld_ready) begin
      push       = (ld_rd != '0);
      push_entry = '{rd: ld_rd, data: ld_data};
    end else if (alu_valid && alu_ready) begin
      push       = (alu_rd != '0);
      push_entry = '{rd: alu_rd, data: alu_data};
    end
  end

  assign pop = !stall && !fifo_empty;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .entry_i   (push_entry),
    .pop_i     (pop),
    .head_c    (fifo_head),
    .count_o   (fifo_count),
    .full_c    (fifo_full),
    .empty_c   (fifo_empty),
    .entries_o (fifo_entries),
    .valid_o   (fifo_valid),
    .rd_ptr_o  (fifo_rd_ptr)
  );

  assign count = fifo_count;

  // Output register: address/data hold when nothing drains.
  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (pop) begin
      we_d   = 1'b1;
      addr_d = fifo_head.rd;
      data_d = fifo_head.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign write_en3   = we_q;
  assign addr3       = addr_q;
  assign write_data3 = data_q;

  always_comb begin
    busy_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (fifo_valid[i]) begin
        busy_mask = busy_mask | reg_onehot(fifo_entries[i].rd);
      end
    end
    if (we_q) begin
      busy_mask = busy_mask | reg_onehot(addr_q);
    end
  end

`ifdef WB_FWD_EN
  logic [PTR_W-1:0] fwd_idx;

  // Walk oldest to youngest so the youngest match overrides the output register.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = fifo_rd_ptr;
    if (we_q && (addr_q == fwd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = data_q;
    end
    for (int unsigned age = 0; age < DEPTH; age++) begin
      fwd_idx = fifo_rd_ptr + PTR_W'(age);
      if (fifo_valid[fwd_idx] && (fifo_entries[fwd_idx].rd == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo_entries[fwd_idx].data;
      end
    end
    if (fwd_addr == '0) begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
    end
  end
`else
  logic unused_fwd;

  always_comb begin
    unused_fwd = (^fwd_addr) ^ (^fifo_rd_ptr);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      unused_fwd = unused_fwd ^ (^fifo_entries[i].data);
    end
  end

  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

endmodule
